rns2bin_seq: RTL and testbench

Parametrised, handshaked RNS-to-binary converter using the Chinese Remainder Theorem (CRT). It is the successor to the combinational-loop converter.
- Moduli and precomputed CRT weights W_i = (M/m_i)·inv(M/m_i mod m_i) mod M are loaded once through a config port.
- The block computes the dynamic range M and validates the configuration.
- Each conversion is a bit-serial modular multiply-accumulate, one channel at a time, with optional signed (symmetric-range) output.
- It sits between the RNS datapath and binary consumers.

---
 rtl/rns2bin_seq.sv | 152 +++++++++++++++
 tb/tb_rns2bin_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rns2bin_seq.sv
// RNS-to-binary converter (CRT). Moduli and weights are loaded and validated once;
// each vector is then reduced one channel at a time by bit-serial modular multiply-accumulate.
module rns2bin_seq #(
    parameter int MOD_NUM  = 4,
    parameter int MOD_SIZE = 3,
    parameter int RANGE    = MOD_NUM * MOD_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_load,
    input  logic [MOD_NUM*MOD_SIZE-1:0] cfg_mod,
    input  logic [MOD_NUM*RANGE-1:0]    cfg_wt,
    output logic                        cfg_busy,
    output logic                        cfg_ok,
    output logic                        cfg_err,
    output logic [RANGE-1:0]            dyn_range,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MOD_NUM*MOD_SIZE-1:0] in_res,
    input  logic                        in_signed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RANGE-1:0]            out_data,
    output logic                        out_err
);
    localparam int CW = (MOD_NUM > 1) ? $clog2(MOD_NUM) : 1;
    localparam int BW = $clog2(MOD_SIZE + 1);

    typedef enum logic [2:0] {UNCFG, CFG_MUL, CFG_CHK, IDLE, CONV, DONE} state_t;
    state_t state, state_nxt;

    logic [MOD_SIZE-1:0] mods  [MOD_NUM];
    logic [RANGE-1:0]    wts   [MOD_NUM];
    logic [MOD_SIZE-1:0] res_r [MOD_NUM];
    logic [RANGE-1:0]    m_acc, acc;
    logic [RANGE:0]      p;
    logic [CW-1:0]       ch;
    logic [BW-1:0]       bcnt;
    logic                fin, chk_err, signed_r, err_r;

    logic [MOD_SIZE-1:0] mod_cur, res_cur;
    logic [RANGE-1:0]    wt_cur;
    logic                last_ch, last_bit, cur_bit, chk_now, in_bad;
    logic [RANGE:0]      mx, half, p_dbl, p_red, p_add, p_nxt, acc_sum, acc_nxt;

    always_comb begin
        mod_cur  = mods[ch];
        wt_cur   = wts[ch];
        res_cur  = res_r[ch];
        last_ch  = (ch == CW'(MOD_NUM - 1));
        last_bit = (bcnt == BW'(MOD_SIZE));
        chk_now  = (mod_cur <= MOD_SIZE'(1)) || (wt_cur >= m_acc);
        mx       = {1'b0, m_acc};
        half     = (mx + 1'b1) >> 1;
        cur_bit  = 1'b0;
        for (int unsigned b = 0; b < MOD_SIZE; b++)
            if (bcnt == BW'(MOD_SIZE - 1 - b)) cur_bit = res_cur[b];
        // p and acc stay below M, so one conditional subtract restores each invariant
        p_dbl   = {p[RANGE-1:0], 1'b0};
        p_red   = (p_dbl >= mx) ? p_dbl - mx : p_dbl;
        p_add   = p_red + {1'b0, wt_cur};
        p_nxt   = cur_bit ? ((p_add >= mx) ? p_add - mx : p_add) : p_red;
        acc_sum = {1'b0, acc} + p;
        acc_nxt = (acc_sum >= mx) ? acc_sum - mx : acc_sum;
        in_bad  = 1'b0;
        for (int unsigned i = 0; i < MOD_NUM; i++)
            if (in_res[i*MOD_SIZE +: MOD_SIZE] >= mods[i]) in_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= UNCFG;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNCFG:   if (cfg_load) state_nxt = CFG_MUL;
            CFG_MUL: if (last_ch) state_nxt = CFG_CHK;
            CFG_CHK: if (last_ch) state_nxt = (chk_err || chk_now) ? UNCFG : IDLE;
            IDLE:    if (cfg_load) state_nxt = CFG_MUL;
                     else if (in_valid) state_nxt = CONV;
            CONV:    if (fin) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = UNCFG;
        endcase
    end

    always_comb begin
        cfg_busy  = (state == CFG_MUL) || (state == CFG_CHK);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dyn_range = cfg_ok ? m_acc : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_acc <= '0; acc <= '0; p <= '0; ch <= '0; bcnt <= '0;
            fin <= 1'b0; chk_err <= 1'b0; signed_r <= 1'b0; err_r <= 1'b0;
            cfg_ok <= 1'b0; cfg_err <= 1'b0; out_data <= '0; out_err <= 1'b0;
        end else begin
            case (state)
                UNCFG, IDLE: begin
                    if (cfg_load) begin
                        for (int unsigned i = 0; i < MOD_NUM; i++) begin
                            mods[i] <= cfg_mod[i*MOD_SIZE +: MOD_SIZE];
                            wts[i]  <= cfg_wt[i*RANGE +: RANGE];
                        end
                        m_acc <= RANGE'(1); ch <= '0; chk_err <= 1'b0;
                        cfg_ok <= 1'b0; cfg_err <= 1'b0;
                    end else if (state == IDLE && in_valid) begin
                        for (int unsigned i = 0; i < MOD_NUM; i++)
                            res_r[i] <= in_res[i*MOD_SIZE +: MOD_SIZE];
                        signed_r <= in_signed; err_r <= in_bad;
                        acc <= '0; p <= '0; ch <= '0; bcnt <= '0; fin <= 1'b0;
                    end
                end
                CFG_MUL: begin
                    m_acc <= m_acc * RANGE'(mod_cur);
                    ch    <= last_ch ? '0 : ch + CW'(1);
                end
                CFG_CHK: begin
                    chk_err <= chk_err | chk_now;
                    ch      <= last_ch ? '0 : ch + CW'(1);
                    if (last_ch) begin
                        if (chk_err || chk_now) cfg_err <= 1'b1;
                        else                    cfg_ok  <= 1'b1;
                    end
                end
                CONV: begin
                    if (fin) begin
                        if (err_r)                          out_data <= '0;
                        else if (signed_r && {1'b0, acc} >= half) out_data <= acc - m_acc;
                        else                                out_data <= acc;
                        out_err <= err_r;
                    end else if (last_bit) begin
                        acc  <= acc_nxt[RANGE-1:0];
                        p    <= '0;
                        bcnt <= '0;
                        if (last_ch) fin <= 1'b1;
                        else         ch  <= ch + CW'(1);
                    end else begin
                        p    <= p_nxt;
                        bcnt <= bcnt + BW'(1);
                    end
                end
                DONE: if (out_ready) out_err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rns2bin_seq.sv
// Randomized bench for rns2bin_seq against a plain-arithmetic CRT reference
// (X = sum c_i*W_i mod M, symmetric-range fold when signed).
module tb_rns2bin_seq;
    localparam int N = 4;
    localparam int S = 3;
    localparam int R = N * S;

    logic clk = 1'b0, reset = 1'b1, cfg_load = 1'b0;
    logic in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
    logic [N*S-1:0] cfg_mod = '0, in_res = '0;
    logic [N*R-1:0] cfg_wt = '0;
    logic cfg_busy, cfg_ok, cfg_err, in_ready, out_valid, out_err;
    logic [R-1:0] dyn_range, out_data;

    int total = 0, bad = 0;
    int cm[N], cw[N], cr[N];
    int cur_m[N], cur_w[N];

    rns2bin_seq #(.MOD_NUM(N), .MOD_SIZE(S)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_mod(cfg_mod), .cfg_wt(cfg_wt),
        .cfg_busy(cfg_busy), .cfg_ok(cfg_ok), .cfg_err(cfg_err), .dyn_range(dyn_range),
        .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input bit sgn, output logic [R-1:0] d, output logic e);
        int m, x;
        m = 1;
        for (int i = 0; i < N; i++) m *= cur_m[i];
        x = 0;
        e = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cr[i] >= cur_m[i]) e = 1'b1;
            x = (x + cr[i] * cur_w[i]) % m;
        end
        if (e)                          d = '0;
        else if (sgn && x >= (m + 1) / 2) d = R'(x - m);
        else                            d = R'(x);
    endfunction

    task automatic configure;
        int n, m;
        bit ok;
        for (int i = 0; i < N; i++) begin
            cfg_mod[i*S +: S] = S'(cm[i]);
            cfg_wt[i*R +: R]  = R'(cw[i]);
        end
        cfg_load = 1'b1;
        tick;
        cfg_load = 1'b0;
        n = 0;
        while (cfg_busy && n < 50) begin
            tick;
            n++;
        end
        check("cfg_cycles", n, 2 * N);
        m = 1;
        for (int i = 0; i < N; i++) m *= cm[i];
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (cm[i] < 2 || cw[i] >= m) ok = 1'b0;
        check("cfg_ok", cfg_ok, ok);
        check("cfg_err", cfg_err, !ok);
        check("dyn_range", dyn_range, ok ? m : 0);
        check("cfg_in_ready", in_ready, ok);
        if (ok) begin
            cur_m = cm;
            cur_w = cw;
        end
    endtask

    task automatic convert(input bit sgn, input int hold, input bit inj, input bit noise);
        int n;
        logic [R-1:0] ed;
        logic ee;
        model(sgn, ed, ee);
        check("in_ready_pre", in_ready, 1);
        for (int i = 0; i < N; i++) in_res[i*S +: S] = S'(cr[i]);
        in_signed = sgn;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            cfg_load = inj && (n == 5);
            if (cfg_load) cfg_mod = '0;
            if (noise) begin
                in_valid  = 1'b1;
                in_res    = N*S'($urandom);
                in_signed = ~sgn;
            end
            tick;
            n++;
        end
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check("latency", n, N * (S + 1) + 1);
        check("out_data", out_data, ed);
        check("out_err", out_err, ee);
        for (int k = 0; k < hold; k++) begin
            tick;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, ed);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("consumed_valid", out_valid, 0);
        check("consumed_err", out_err, 0);
        check("consumed_data", out_data, ed);
        check("in_ready_post", in_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        tick;
        tick;
        check("rst_busy", cfg_busy, 0);
        check("rst_ok", cfg_ok, 0);
        check("rst_err", cfg_err, 0);
        check("rst_range", dyn_range, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        reset = 1'b0;
        tick;

        cm = '{3, 4, 5, 7};
        cw = '{280, 105, 336, 120};
        configure;

        cr = '{1, 0, 0, 2}; convert(0, 0, 0, 0);
        check("spec_100", out_data, 100);
        cr = '{2, 3, 4, 6}; convert(0, 0, 0, 0);
        check("spec_419", out_data, 419);
        convert(1, 0, 0, 0);
        check("spec_minus1", out_data, 12'hFFF);
        cr = '{0, 2, 0, 0}; convert(1, 0, 0, 0);
        check("spec_minus210", out_data, 12'hF2E);
        cr = '{2, 1, 4, 6}; convert(1, 0, 0, 0);
        check("spec_209", out_data, 209);
        cr = '{1, 2, 3, 4}; convert(0, 10, 0, 0);
        cr = '{3, 0, 0, 0}; convert(0, 0, 0, 0);
        check("spec_illegal", out_err, 0);
        cr = '{0, 0, 0, 0}; convert(1, 0, 0, 0);
        cr = '{2, 3, 4, 6}; convert(0, 0, 1, 1);
        check("inj_cfg_ok", cfg_ok, 1);
        check("inj_range", dyn_range, 420);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) cr[i] = $urandom_range(cur_m[i] - 1, 0);
            if ($urandom_range(5, 0) == 0) begin
                int k;
                k = $urandom_range(N - 1, 0);
                cr[k] = $urandom_range(7, cur_m[k]);
            end
            convert($urandom_range(1, 0) == 1, $urandom_range(3, 0), 0, $urandom_range(1, 0) == 1);
        end

        cw = '{420, 105, 336, 120};
        configure;
        repeat (3) tick;
        check("badw_in_ready", in_ready, 0);
        cm = '{3, 1, 5, 7};
        cw = '{35, 0, 21, 15};
        configure;
        cm = '{3, 4, 5, 7};
        cw = '{280, 105, 336, 120};
        configure;

        for (int i = 0; i < N; i++) in_res[i*S +: S] = '0;
        in_res[0 +: S]   = 3'd1;
        in_res[3*S +: S] = 3'd2;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (7) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_busy", cfg_busy, 0);
        check("mid_ok", cfg_ok, 0);
        check("mid_err", cfg_err, 0);
        check("mid_range", dyn_range, 0);
        check("mid_in_ready", in_ready, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_data", out_data, 0);
        check("mid_out_err", out_err, 0);
        repeat (4) tick;
        check("mid_still_unready", in_ready, 0);
        configure;
        cr = '{1, 0, 0, 2}; convert(0, 0, 0, 0);
        check("after_reset_100", out_data, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
